vote_collector: RTL and testbench

Session-based ballot collector that sits directly upstream of the 4-input majority voter. It opens a voting window on `start` and latches the first vote from each of four voters. It closes the window when all four have voted or a timeout expires. The frozen ballot is then presented on bits A..D with a valid/ready handshake, so the voter always sees a stable, complete input vector.

---
 rtl/vote_collector_if.sv | 41 ++++
 rtl/vote_collector.sv | 99 +++++++++
 tb/tb_vote_collector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_collector_if.sv
// Bundle of the ballot collector's session, vote and handshake signals.
interface vote_collector_if;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_value;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic       ballot_ready;
    logic [3:0] voted;
    logic       busy;
    logic       timed_out;
    logic [7:0] session_count;

    // Collector side.
    modport slave (
        input  start,
        input  vote_valid,
        input  vote_value,
        input  ballot_ready,
        output ballot,
        output ballot_valid,
        output voted,
        output busy,
        output timed_out,
        output session_count
    );

    // Voter/consumer side.
    modport master (
        output start,
        output vote_valid,
        output vote_value,
        output ballot_ready,
        input  ballot,
        input  ballot_valid,
        input  voted,
        input  busy,
        input  timed_out,
        input  session_count
    );
endinterface

// File: rtl/vote_collector.sv
// Session-based ballot collector: latches the first vote from each of four
// voters within a timed window, then presents the frozen ballot via valid/ready.
module vote_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    vote_collector_if.slave   bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOpen = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [CNT_W-1:0] TimerMax = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       ballot_q, ballot_d;
    logic [3:0]       voted_q, voted_d;
    logic             timed_out_q, timed_out_d;
    logic [7:0]       count_q, count_d;
    logic [3:0]       capture;

    // Next-state logic: session open, vote capture, close decision, handshake.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ballot_d    = ballot_q;
        voted_d     = voted_q;
        timed_out_d = timed_out_q;
        count_d     = count_q;
        // Only voters that have not yet voted are captured (first vote wins).
        capture     = bus.vote_valid & ~voted_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StOpen;
                    timer_d     = '0;
                    ballot_d    = '0;
                    voted_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            StOpen: begin
                ballot_d = (ballot_q & ~capture) | (bus.vote_value & capture);
                voted_d  = voted_q | capture;
                // Close test sees this cycle's captures, so a late vote still counts.
                if (&voted_d) begin
                    state_d = StDone;
                end else if (timer_q == TimerMax) begin
                    state_d     = StDone;
                    timed_out_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.ballot_ready) begin
                    state_d = StIdle;
                    count_d = count_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            ballot_q    <= '0;
            voted_q     <= '0;
            timed_out_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ballot_q    <= ballot_d;
            voted_q     <= voted_d;
            timed_out_q <= timed_out_d;
            count_q     <= count_d;
        end
    end

    // Outputs decoded purely from registers; no input-to-output path.
    assign bus.ballot        = ballot_q;
    assign bus.voted         = voted_q;
    assign bus.timed_out     = timed_out_q;
    assign bus.session_count = count_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.ballot_valid  = (state_q == StDone);

endmodule

// File: tb/tb_vote_collector.sv
// Randomized bench for vote_collector against a session-level ballot model.
module tb_vote_collector;

    localparam int unsigned T = 16;

    logic clk;
    logic rst_n;

    vote_collector_if vif ();

    vote_collector #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int exp_count;

    // Per-session vote schedule, indexed by OPEN cycle number.
    logic [3:0] sch_v [256];
    logic [3:0] sch_x [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        vif.start      = 1'($urandom);
        vif.vote_valid = 4'($urandom);
        vif.vote_value = 4'($urandom);
    endtask

    task automatic clear_sched();
        for (int k = 0; k < 256; k++) begin
            sch_v[k] = '0;
            sch_x[k] = '0;
        end
    endtask

    task automatic put(input int k, input int i, input logic val);
        sch_v[k][i] = 1'b1;
        sch_x[k][i] = val;
    endtask

    task automatic fill_random();
        logic [3:0] missing;
        int         dens;
        clear_sched();
        missing = ($urandom_range(0, 1) == 0) ? 4'($urandom) & 4'($urandom) : 4'b0000;
        dens    = $urandom_range(1, 8);
        for (int k = 0; k < int'(T); k++) begin
            for (int i = 0; i < 4; i++) begin
                sch_v[k][i] = !missing[i] && ($urandom_range(0, 15) < dens);
            end
            sch_x[k] = 4'($urandom);
        end
    endtask

    // Model the session from its schedule, then drive it and compare.
    task automatic run_session(input int hold);
        int         first [4];
        int         close;
        bit         all_in;
        logic [3:0] eb;
        logic [3:0] em;
        logic       et;

        eb = '0;
        em = '0;
        for (int i = 0; i < 4; i++) begin
            first[i] = -1;
            for (int k = 0; k < int'(T); k++) begin
                if (first[i] < 0 && sch_v[k][i]) first[i] = k;
            end
        end
        all_in = 1'b1;
        close  = 0;
        for (int i = 0; i < 4; i++) begin
            if (first[i] < 0) all_in = 1'b0;
            else if (first[i] > close) close = first[i];
            if (first[i] >= 0) begin
                em[i] = 1'b1;
                eb[i] = sch_x[first[i]][i];
            end
        end
        if (!all_in) close = int'(T) - 1;
        et = !all_in;

        // IDLE cycle with start; votes here must be ignored.
        vif.start        = 1'b1;
        vif.vote_valid   = 4'($urandom);
        vif.vote_value   = 4'($urandom);
        vif.ballot_ready = 1'($urandom);
        step();
        check("busy_open", 32'(vif.busy), 32'd1);
        check("voted_clr", 32'(vif.voted), 32'd0);
        check("ballot_clr", 32'(vif.ballot), 32'd0);
        check("tout_clr", 32'(vif.timed_out), 32'd0);

        for (int k = 0; k <= close; k++) begin
            vif.start        = 1'($urandom);
            vif.vote_valid   = sch_v[k];
            vif.vote_value   = sch_x[k];
            vif.ballot_ready = 1'($urandom);
            step();
            check("bvalid_open", 32'(vif.ballot_valid), 32'(k == close));
        end

        check("ballot", 32'(vif.ballot), 32'(eb));
        check("voted", 32'(vif.voted), 32'(em));
        check("timed_out", 32'(vif.timed_out), 32'(et));
        check("busy_done", 32'(vif.busy), 32'd1);

        for (int h = 0; h < hold; h++) begin
            junk_inputs();
            vif.ballot_ready = 1'b0;
            step();
            check("bvalid_hold", 32'(vif.ballot_valid), 32'd1);
            check("ballot_hold", 32'(vif.ballot), 32'(eb));
            check("voted_hold", 32'(vif.voted), 32'(em));
        end

        junk_inputs();
        vif.ballot_ready = 1'b1;
        step();
        exp_count = (exp_count + 1) % 256;
        check("bvalid_after", 32'(vif.ballot_valid), 32'd0);
        check("busy_after", 32'(vif.busy), 32'd0);
        check("count", 32'(vif.session_count), 32'(exp_count));
        check("ballot_kept", 32'(vif.ballot), 32'(eb));
        check("tout_kept", 32'(vif.timed_out), 32'(et));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ballot"}, 32'(vif.ballot), 32'd0);
        check({tag, "_voted"}, 32'(vif.voted), 32'd0);
        check({tag, "_bvalid"}, 32'(vif.ballot_valid), 32'd0);
        check({tag, "_busy"}, 32'(vif.busy), 32'd0);
        check({tag, "_tout"}, 32'(vif.timed_out), 32'd0);
        check({tag, "_count"}, 32'(vif.session_count), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        vif.ballot_ready = 1'b0;
        junk_inputs();

        // Reset held 3 cycles with random inputs.
        for (int c = 0; c < 3; c++) begin
            junk_inputs();
            vif.ballot_ready = 1'($urandom);
            step();
        end
        check_reset_state("rst");
        rst_n = 1'b1;

        // Full ballot, A..D on separate cycles, ready immediately.
        clear_sched();
        put(0, 0, 1'b1);
        put(1, 1, 1'b0);
        put(2, 2, 1'b1);
        put(3, 3, 1'b1);
        run_session(0);

        // Abort mid-session with reset.
        vif.start      = 1'b1;
        vif.vote_valid = '0;
        step();
        for (int c = 0; c < 3; c++) begin
            junk_inputs();
            step();
        end
        rst_n = 1'b0;
        step();
        exp_count = 0;
        check_reset_state("abort");
        rst_n = 1'b1;
        vif.start = 1'b0;
        step();

        // First vote wins.
        clear_sched();
        put(0, 0, 1'b1);
        put(1, 0, 1'b0);
        put(2, 1, 1'b0);
        put(2, 2, 1'b0);
        put(2, 3, 1'b0);
        run_session(1);

        // Timeout with only B and C voting.
        clear_sched();
        put(2, 1, 1'b1);
        put(5, 2, 1'b1);
        run_session(0);

        // Same, plus D in the final window cycle.
        put(int'(T) - 1, 3, 1'b1);
        run_session(2);

        // No votes at all, and all four in the first cycle.
        clear_sched();
        run_session(0);
        clear_sched();
        put(0, 0, 1'b0);
        put(0, 1, 1'b1);
        put(0, 2, 1'b0);
        put(0, 3, 1'b1);
        run_session(0);

        // Backpressure: ten stalled DONE cycles with toggling inputs.
        fill_random();
        run_session(10);

        // Random sessions; enough of them to wrap the session counter.
        for (int s = 0; s < 270; s++) begin
            int gap;
            fill_random();
            run_session($urandom_range(0, 3));
            gap = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
            for (int g = 0; g < gap; g++) begin
                vif.start        = 1'b0;
                vif.vote_valid   = 4'($urandom);
                vif.vote_value   = 4'($urandom);
                vif.ballot_ready = 1'($urandom);
                step();
                check("idle_busy", 32'(vif.busy), 32'd0);
                check("idle_count", 32'(vif.session_count), 32'(exp_count));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
